// File: rtl/trap_csr_unit.sv
// Machine-mode trap/CSR unit: records traps, services mret and Zicsr accesses,
// runs the flush/redirect handshake and the mcycle/minstret counters.
module trap_csr_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_req,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [3:0]      exc_cause,
    input  logic [XLEN-1:0] exc_tval,
    output logic            exc_ack,
    input  logic            mret_req,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            retire,
    output logic            flush_req,
    input  logic            flush_ack,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

    state_t          state;
    logic            mie;
    logic            mpie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;
    logic [XLEN-1:0] target;
    logic [63:0]     mcycle;
    logic [63:0]     minstret;

    logic            csr_hit;
    logic [XLEN-1:0] wval;
    logic            csr_we;
    logic            take_trap;
    logic            take_mret;
    logic [63:0]     mcycle_inc;
    logic [63:0]     minstret_inc;

    always_comb begin
        csr_hit   = 1'b1;
        csr_rdata = '0;
        case (csr_addr)
            A_MSTATUS: begin
                csr_rdata[3] = mie;
                csr_rdata[7] = mpie;
            end
            A_MTVEC:     csr_rdata = mtvec;
            A_MEPC:      csr_rdata = mepc;
            A_MCAUSE:    csr_rdata = mcause;
            A_MTVAL:     csr_rdata = mtval;
            A_MCYCLE:    csr_rdata = XLEN'(mcycle[31:0]);
            A_MCYCLEH:   csr_rdata = XLEN'(mcycle[63:32]);
            A_MINSTRET:  csr_rdata = XLEN'(minstret[31:0]);
            A_MINSTRETH: csr_rdata = XLEN'(minstret[63:32]);
            default:     csr_hit   = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op)
            OP_WRITE: wval = csr_wdata;
            OP_SET:   wval = csr_rdata | csr_wdata;
            OP_CLEAR: wval = csr_rdata & ~csr_wdata;
            default:  wval = csr_rdata;
        endcase
    end

    assign take_trap   = (state == IDLE) && exc_req;
    assign take_mret   = (state == IDLE) && mret_req && !exc_req;
    assign csr_illegal = (csr_op != OP_NONE) && !csr_hit;

    // set/clear with a zero mask must not write, otherwise a counter would
    // lose its increment for that cycle.
    assign csr_we = (state == IDLE) && (csr_op != OP_NONE) && csr_hit
                    && !exc_req && !mret_req
                    && !((csr_op != OP_WRITE) && (csr_wdata == '0));

    assign exc_ack     = take_trap;
    assign flush_req   = (state == FLUSH);
    assign redirect    = (state == REDIRECT);
    assign busy        = (state != IDLE);
    assign redirect_pc = target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mie    <= 1'b0;
            mpie   <= 1'b0;
            mtvec  <= MTVEC_RESET;
            mepc   <= '0;
            mcause <= '0;
            mtval  <= '0;
            target <= '0;
        end else begin
            if (csr_we) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        mie  <= wval[3];
                        mpie <= wval[7];
                    end
                    A_MTVEC:  mtvec  <= {wval[XLEN-1:2], 2'b00};
                    A_MEPC:   mepc   <= {wval[XLEN-1:2], 2'b00};
                    A_MCAUSE: mcause <= wval;
                    A_MTVAL:  mtval  <= wval;
                    default:  ;
                endcase
            end
            case (state)
                IDLE: begin
                    if (take_trap) begin
                        mepc   <= {exc_pc[XLEN-1:2], 2'b00};
                        mcause <= XLEN'(exc_cause);
                        mtval  <= exc_tval;
                        mpie   <= mie;
                        mie    <= 1'b0;
                        target <= mtvec;
                        state  <= FLUSH;
                    end else if (take_mret) begin
                        mie    <= mpie;
                        mpie   <= 1'b1;
                        target <= mepc;
                        state  <= FLUSH;
                    end
                end
                FLUSH:    if (flush_ack) state <= REDIRECT;
                REDIRECT: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    assign mcycle_inc   = mcycle + 64'd1;
    assign minstret_inc = minstret + {63'd0, retire && (state == IDLE)};

    // Each half takes the write or the incremented value, so a carry out of
    // an unwritten low half still reaches the high half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            mcycle   <= mcycle_inc;
            minstret <= minstret_inc;
            if (csr_we) begin
                case (csr_addr)
                    A_MCYCLE:    mcycle[31:0]    <= wval[31:0];
                    A_MCYCLEH:   mcycle[63:32]   <= wval[31:0];
                    A_MINSTRET:  minstret[31:0]  <= wval[31:0];
                    A_MINSTRETH: minstret[63:32] <= wval[31:0];
                    default:     ;
                endcase
            end
        end
    end
endmodule

// File: doc/trap_csr_unit.md
Name: trap_csr_unit

Overview:
- Machine-mode trap/CSR block directly downstream of the exception unit.
- Accepts trap requests carrying faulting PC and cause, records them in mepc/mcause/mtval, and updates mstatus.
- Flushes the pipeline through a handshake with the hazard unit, then issues a one-cycle redirect to mtvec.
- Also services mret, Zicsr read/write/set/clear from the execute stage, and the mcycle/minstret counters.

Parameters:
- XLEN, 32, data/PC width (word_t).
- MTVEC_RESET, 32'h0000_0100, reset value of mtvec.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- exc_req  input  1  trap request from exception unit (level; held until exc_ack).
- exc_pc  input  XLEN  PC of faulting instruction.
- exc_cause  input  4  mcause code (2 = illegal inst, 3 = breakpoint, 11 = ecall-M).
- exc_tval  input  XLEN  trap value (faulting instruction word or 0).
- exc_ack  output  1  one-cycle pulse: trap accepted.
- mret_req  input  1  mret in execute (single-cycle pulse).
- csr_op  input  2  0 none, 1 write, 2 set, 3 clear.
- csr_addr  input  12  CSR address.
- csr_wdata  input  XLEN  operand (rs1 or zimm).
- csr_rdata  output  XLEN  combinational old value of csr_addr.
- csr_illegal  output  1  combinational: csr_op!=0 and address unimplemented.
- retire  input  1  instruction retired this cycle.
- flush_req  output  1  request pipeline flush.
- flush_ack  input  1  hazard unit confirms flush complete.
- redirect  output  1  one-cycle PC redirect strobe.
- redirect_pc  output  XLEN  target PC, valid with redirect.
- busy  output  1  FSM not in IDLE; hazard stalls fetch.

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: only MIE bit3 and MPIE bit7 writable; other bits read 0.
  - mtvec 0x305: bits[1:0] forced 0.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342, mtval 0x343.
  - mcycle 0xB00 / mcycleh 0xB80, minstret 0xB02 / minstreth 0xB82.
- Reset: all outputs 0; state IDLE; mtvec=MTVEC_RESET; all other CSRs 0.
- FSM states: IDLE, FLUSH, REDIRECT.
  - IDLE + exc_req:
    - In the same cycle: pulse exc_ack.
    - Next edge: mepc<=exc_pc, mcause<=exc_cause zero-extended, mtval<=exc_tval, MPIE<=MIE, MIE<=0.
    - Go to FLUSH.
  - IDLE + mret_req and no exc_req:
    - Next edge: MIE<=MPIE, MPIE<=1.
    - Go to FLUSH with target mepc.
  - FLUSH:
    - flush_req=1 until flush_ack is sampled high.
    - Then go to REDIRECT; flush_ack in the same cycle as entry is honoured.
  - REDIRECT:
    - redirect=1 for exactly one cycle, redirect_pc = latched target (mtvec for trap, mepc for mret).
    - Return to IDLE.
- Latency: exc_req rising → redirect no sooner than cycle 3 (IDLE→FLUSH→REDIRECT with immediate ack).
- Priority, same cycle: exc_req > mret_req > CSR write. A CSR write coincident with exc_req or mret_req is dropped. A CSR write is applied only in IDLE.
- exc_req or mret_req outside IDLE: ignored, no ack. Exception unit holds exc_req until acknowledged.
- CSR write rules:
  - write: new=wdata; set: old|wdata; clear: old&~wdata.
  - Applied at clock edge. Writes to counters override the increment that cycle.
  - Writes to unimplemented addresses are ignored.
  - set/clear with wdata=0 performs no state change.
- Counters:
  - mcycle: 64-bit, +1 every cycle, wraps 0xFFFF_FFFF_FFFF_FFFF → 0.
  - minstret: +1 when retire=1 and state==IDLE.
  - 32-bit halves are written independently; the carry from low to high is kept.
- Reset mid-operation: FSM returns to IDLE immediately; no redirect is emitted; CSRs reinitialise.

Test Plan:
- Reset then read 0x305 → csr_rdata=32'h100; all outputs 0, busy=0.
- Write mtvec=0x203, set MIE; exc_req with pc=0x40, cause=2, tval=0xFFFF_FFFF, flush_ack tied 1:
  - exc_ack pulses.
  - mepc=0x40, mcause=2, mtval=0xFFFF_FFFF, MIE=0, MPIE=1.
  - redirect=1 with redirect_pc=0x200 exactly one cycle.
- Hold flush_ack=0 for 5 cycles during trap → flush_req held 5 cycles, redirect only after ack; a second exc_req during FLUSH gets no ack.
- mret after trap → MIE=1, MPIE=1, redirect_pc=0x40.
- Same-cycle exc_req and csr_op=1 to mepc → write dropped, mepc=exc_pc; csr_op=3 to 0x300 with wdata=0x8 clears MIE only.
- Preload mcycle=0xFFFF_FFFF via 0xB00 → next cycle mcycle=0, mcycleh=1. Pulse retire while busy → minstret unchanged. Assert rst during FLUSH → busy=0, no redirect.
